// File: rtl/eeprom_arb_pkg.sv
// eeprom_arb_pkg: shared types and defaults for the two-port EEPROM arbiter.
// Holds the arbiter FSM state enum and the default ADDR_W / TIMEOUT_CYC values.
// No ports; imported by eeprom_arb and eeprom_arb_rr.
package eeprom_arb_pkg;

  localparam int ADDR_W_DEF      = 11;    // EEPROM byte-address width
  localparam int TIMEOUT_CYC_DEF = 4095;  // WAIT_ACK cycles before abort

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    RESP     = 3'd4,
    GAP      = 3'd5
  } state_e;

endpackage

// File: rtl/eeprom_arb_rr.sv
// eeprom_arb_rr: two-way round-robin picker, purely combinational (0 cycles).
// No backpressure; grant is valid whenever any valid bit is set.
// Ports: valid_i[1:0] requests, last_i port last served (1 = port 1),
//        grant_o[1:0] one-hot winner (0 when nothing is valid).
module eeprom_arb_rr
  import eeprom_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Tie: serve whichever port was not served last.
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/eeprom_arb.sv
// eeprom_arb: arbitrates two requesters onto one serial EEPROM engine, one byte op at a time.
// Latency: REQ_VALID seen in IDLE -> ENG_WR/ENG_RD 2 cycles later; REQ_DONE one cycle after ENG_ACK.
// Backpressure: requesters hold their command until REQ_READY; nothing is queued.
// Ports: CLK, RESET (sync, active high); REQ_VALID/REQ_WE/REQ_ADDR/REQ_WDATA per-port commands
//        (port 0 in the low slice); REQ_READY/REQ_DONE one-hot strobes, REQ_ERR/RDATA valid with
//        REQ_DONE; ENG_WR/ENG_RD/ENG_ADDR/ENG_WDATA to the engine, ENG_RDATA/ENG_ACK from it.
// Build option: define EEPROM_ARB_TIMEOUT_EN to abort WAIT_ACK after TIMEOUT_CYC cycles
//        with REQ_ERR=1; otherwise WAIT_ACK waits forever and REQ_ERR is tied low.
module eeprom_arb
  import eeprom_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          REQ_VALID,
  input  logic [1:0]          REQ_WE,
  input  logic [2*ADDR_W-1:0] REQ_ADDR,
  input  logic [15:0]         REQ_WDATA,
  output logic [1:0]          REQ_READY,
  output logic [1:0]          REQ_DONE,
  output logic                REQ_ERR,
  output logic [7:0]          RDATA,
  output logic                ENG_WR,
  output logic                ENG_RD,
  output logic [ADDR_W-1:0]   ENG_ADDR,
  output logic [7:0]          ENG_WDATA,
  input  logic [7:0]          ENG_RDATA,
  input  logic                ENG_ACK
);

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [1:0]          rr_grant;

`ifdef EEPROM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_q;
  logic        err_q, err_d;
`endif

  eeprom_arb_rr u_rr (
    .valid_i (REQ_VALID),
    .last_i  (last_q),
    .grant_o (rr_grant)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;          // port 1 "last served" so port 0 wins the first tie
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef EEPROM_ARB_TIMEOUT_EN
  // Counts WAIT_ACK cycles; restarted in ISSUE so each command gets a full budget.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_q == ISSUE)         cnt_q <= 16'd0;
      else if (state_q == WAIT_ACK) cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign REQ_ERR = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    REQ_READY = 2'b00;
    REQ_DONE  = 2'b00;
    RDATA     = 8'h00;
    ENG_WR    = 1'b0;
    ENG_RD    = 1'b0;
    ENG_ADDR  = '0;
    ENG_WDATA = 8'h00;
`ifdef EEPROM_ARB_TIMEOUT_EN
    err_d     = err_q;
    REQ_ERR   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (|REQ_VALID) begin
          grant_d = rr_grant;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Requester holds its command until this strobe, so latching here is safe.
        REQ_READY = grant_q;
        we_d      = grant_q[1] ? REQ_WE[1] : REQ_WE[0];
        addr_d    = grant_q[1] ? REQ_ADDR[2*ADDR_W-1:ADDR_W] : REQ_ADDR[ADDR_W-1:0];
        wdata_d   = grant_q[1] ? REQ_WDATA[15:8] : REQ_WDATA[7:0];
        rdata_d   = 8'h00;
`ifdef EEPROM_ARB_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        state_d   = ISSUE;
      end
      ISSUE: begin
        ENG_WR    = we_q;
        ENG_RD    = ~we_q;
        ENG_ADDR  = addr_q;
        ENG_WDATA = wdata_q;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        ENG_ADDR  = addr_q;
        ENG_WDATA = wdata_q;
        if (ENG_ACK) begin
          rdata_d = we_q ? 8'h00 : ENG_RDATA;
          state_d = RESP;
        end
`ifdef EEPROM_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        ENG_ADDR  = addr_q;
        ENG_WDATA = wdata_q;
        REQ_DONE  = grant_q;
        RDATA     = rdata_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
        REQ_ERR   = err_q;
`endif
        last_d    = grant_q[1];
        state_d   = GAP;
      end
      GAP: begin
        // One idle cycle lets the engine fall back to its own idle state.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
